// File: rtl/axi4_pkg.sv
// axi4_pkg
// Shared AXI4 encodings, engine state types and the burst legality check
// used by the axi4_mem_slave memory endpoint.
// No ports (package).
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;

  // Returns SLVERR for bursts the slave cannot serve: beats wider than the
  // bus, the reserved burst type, or a WRAP length that is not 2/4/8/16.
  function automatic logic [1:0] burst_check(input logic [1:0] burst,
                                             input logic [7:0] len,
                                             input logic [2:0] size,
                                             input logic [2:0] max_size);
    logic bad;
    bad = (size > max_size) || (burst == 2'b11);
    if ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))
      bad = 1'b1;
    return bad ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_mem_slave_if.sv
// axi4_mem_slave_if
// AXI4 channel bundle (AW, W, B, AR, R) without ID/user/sideband signals.
// Parameters: DATA_W data width, ADDR_W address width.
// Modports: master (drives requests), slave (drives responses).
interface axi4_mem_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// axi4_burst_addr_gen
// Combinational next-beat address for one AXI4 burst.
// Ports: addr (current beat address), size, burst, len in;
//        next_addr (address of the following beat) out.
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  input  logic [7:0]        len,
  output logic [ADDR_W-1:0] next_addr
);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] aligned;
  logic [ADDR_W-1:0] wrap_mask;

  // INCR realigns to the beat size so an unaligned start only affects beat
  // one; WRAP keeps the upper bits of the (LEN+1)*2^SIZE window fixed and
  // lets the low bits roll over.
  always_comb begin
    incr      = ONE << size;
    aligned   = addr & ~(incr - ONE);
    wrap_mask = (((ADDR_W'(len)) + ONE) << size) - ONE;
    case (burst)
      BURST_INCR: next_addr = aligned + incr;
      BURST_WRAP: next_addr = (aligned & ~wrap_mask) | ((aligned + incr) & wrap_mask);
      default:    next_addr = addr;
    endcase
  end
endmodule

// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave
// AXI4 slave backed by byte-addressable storage with independent write and
// read engines, FIXED/INCR/WRAP bursts, DECERR/SLVERR signalling and a
// configurable read latency.
// Ports: s_axi_aclk clock, s_axi_resetn async active-low reset,
//        s_axi AXI4 slave modport (AW, W, B, AR, R channels).
module axi4_mem_slave
  import axi4_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                MEM_BYTES  = 65536,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h8000_0000),
  parameter int                RD_LATENCY = 2
) (
  input  logic            s_axi_aclk,
  input  logic            s_axi_resetn,
  axi4_mem_slave_if.slave s_axi
);
  localparam int         STRB_W    = DATA_W / 8;
  localparam int         OFF_W     = $clog2(STRB_W);
  localparam int         MEM_AW    = $clog2(MEM_BYTES);
  localparam int         WORDS     = MEM_BYTES / STRB_W;
  localparam int         IDX_W     = MEM_AW - OFF_W;
  localparam logic [2:0] MAX_SIZE  = 3'(OFF_W);
  localparam logic [3:0] WAIT_LAST = (RD_LATENCY > 1) ? 4'(RD_LATENCY - 2) : 4'd0;

  logic [DATA_W-1:0] mem [WORDS];

  // Held low until the first edge after reset release so AWREADY/ARREADY
  // are not asserted during reset.
  logic live;

  wr_state_t         w_state, w_state_nxt;
  logic [ADDR_W-1:0] w_addr, w_addr_nxt;
  logic [7:0]        w_len, w_beat;
  logic [2:0]        w_size;
  logic [1:0]        w_burst, w_err;
  logic              w_last_err;
  logic              aw_hs, w_hs;
  logic [1:0]        aw_resp;

  rd_state_t         r_state, r_state_nxt;
  logic [ADDR_W-1:0] r_addr, r_addr_nxt;
  logic [7:0]        r_len, r_beat;
  logic [2:0]        r_size;
  logic [1:0]        r_burst, r_err;
  logic [3:0]        r_cnt;
  logic              ar_hs, r_hs, r_last_beat;
  logic [1:0]        ar_resp;
  logic              rd_load, rd_zero, rd_zero_nxt;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;

  // Whole-burst response decided at the address phase; decode errors win.
  function automatic logic [1:0] check_req(input logic [ADDR_W-1:0] addr,
                                           input logic [1:0] burst,
                                           input logic [7:0] len,
                                           input logic [2:0] size);
    if ((addr >> MEM_AW) != (BASE_ADDR >> MEM_AW)) return RESP_DECERR;
    return burst_check(burst, len, size, MAX_SIZE);
  endfunction

  assign aw_resp     = check_req(s_axi.awaddr, s_axi.awburst, s_axi.awlen, s_axi.awsize);
  assign ar_resp     = check_req(s_axi.araddr, s_axi.arburst, s_axi.arlen, s_axi.arsize);
  assign aw_hs       = s_axi.awvalid && s_axi.awready;
  assign w_hs        = s_axi.wvalid && s_axi.wready;
  assign ar_hs       = s_axi.arvalid && s_axi.arready;
  assign r_hs        = s_axi.rvalid && s_axi.rready;
  assign r_last_beat = (r_beat == r_len);

  axi4_burst_addr_gen #(.ADDR_W(ADDR_W)) u_w_addr_gen (
    .addr(w_addr), .size(w_size), .burst(w_burst), .len(w_len), .next_addr(w_addr_nxt)
  );

  axi4_burst_addr_gen #(.ADDR_W(ADDR_W)) u_r_addr_gen (
    .addr(r_addr), .size(r_size), .burst(r_burst), .len(r_len), .next_addr(r_addr_nxt)
  );

  // State registers for both engines; reset drops any burst in flight.
  always_ff @(posedge s_axi_aclk or negedge s_axi_resetn) begin
    if (!s_axi_resetn) begin
      live    <= 1'b0;
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      live    <= 1'b1;
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  // Write engine next state and handshake outputs.
  always_comb begin
    w_state_nxt   = w_state;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi.awready = live;
        if (live && s_axi.awvalid) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        s_axi.wready = 1'b1;
        if (s_axi.wvalid && (w_beat == w_len)) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // A WLAST in the wrong place only downgrades an otherwise OKAY burst.
  assign s_axi.bresp = (w_err != RESP_OKAY) ? w_err :
                       (w_last_err ? RESP_SLVERR : RESP_OKAY);

  // Write burst context: captured at AW, advanced on every W beat.
  always_ff @(posedge s_axi_aclk or negedge s_axi_resetn) begin
    if (!s_axi_resetn) begin
      w_addr     <= '0;
      w_len      <= '0;
      w_beat     <= '0;
      w_size     <= '0;
      w_burst    <= '0;
      w_err      <= RESP_OKAY;
      w_last_err <= 1'b0;
    end else if (aw_hs) begin
      w_addr     <= s_axi.awaddr;
      w_len      <= s_axi.awlen;
      w_beat     <= '0;
      w_size     <= s_axi.awsize;
      w_burst    <= s_axi.awburst;
      w_err      <= aw_resp;
      w_last_err <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_addr_nxt;
      w_beat <= w_beat + 8'd1;
      if (s_axi.wlast != (w_beat == w_len)) w_last_err <= 1'b1;
    end
  end

  // Read engine next state, handshake outputs and storage read control.
  // The read word is registered on the edge that presents a new beat, so
  // RDATA stays put during stalls and a same-cycle write is not seen.
  always_comb begin
    r_state_nxt   = r_state;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    s_axi.rlast   = 1'b0;
    rd_load       = 1'b0;
    rd_idx        = r_addr[MEM_AW-1:OFF_W];
    rd_zero_nxt   = (r_err != RESP_OKAY);
    case (r_state)
      R_IDLE: begin
        s_axi.arready = live;
        if (live && s_axi.arvalid) begin
          if (RD_LATENCY == 1) begin
            r_state_nxt = R_DATA;
            rd_load     = 1'b1;
            rd_idx      = s_axi.araddr[MEM_AW-1:OFF_W];
            rd_zero_nxt = (ar_resp != RESP_OKAY);
          end else begin
            r_state_nxt = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt == WAIT_LAST) begin
          r_state_nxt = R_DATA;
          rd_load     = 1'b1;
        end
      end
      R_DATA: begin
        s_axi.rvalid = 1'b1;
        s_axi.rlast  = r_last_beat;
        if (s_axi.rready) begin
          if (r_last_beat) begin
            r_state_nxt = R_IDLE;
          end else begin
            rd_load = 1'b1;
            rd_idx  = r_addr_nxt[MEM_AW-1:OFF_W];
          end
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign s_axi.rresp = r_err;
  assign s_axi.rdata = rd_zero ? '0 : rd_word;

  // Read burst context plus the flag that blanks RDATA for error bursts
  // (and out of reset, since storage is never cleared).
  always_ff @(posedge s_axi_aclk or negedge s_axi_resetn) begin
    if (!s_axi_resetn) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_err   <= RESP_OKAY;
      r_cnt   <= '0;
      rd_zero <= 1'b1;
    end else begin
      if (ar_hs) begin
        r_addr  <= s_axi.araddr;
        r_len   <= s_axi.arlen;
        r_beat  <= '0;
        r_size  <= s_axi.arsize;
        r_burst <= s_axi.arburst;
        r_err   <= ar_resp;
        r_cnt   <= '0;
      end else begin
        if (r_state == R_WAIT) r_cnt <= r_cnt + 4'd1;
        if (r_hs) begin
          r_addr <= r_addr_nxt;
          r_beat <= r_beat + 8'd1;
        end
      end
      if (rd_load) rd_zero <= rd_zero_nxt;
    end
  end

  // Storage: byte-lane writes for error-free bursts, registered read port.
  always_ff @(posedge s_axi_aclk) begin
    if (w_hs && (w_err == RESP_OKAY)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) mem[w_addr[MEM_AW-1:OFF_W]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
    if (rd_load) rd_word <= mem[rd_idx];
  end

endmodule

// File: tb/tb_axi4_mem_slave.sv
// tb_axi4_mem_slave
// Directed bench for axi4_mem_slave: a byte-lane memory model and burst
// address model build expected read beats and write responses, which are
// queued when a request is issued and compared as the DUT answers.
module tb_axi4_mem_slave;
  import axi4_pkg::*;

  localparam int TMO        = 200;
  localparam int RD_LATENCY = 2;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  rbeat_t      r_q[$];
  logic [1:0]  b_q[$];
  logic [31:0] model [logic [31:0]];

  axi4_mem_slave_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  axi4_mem_slave #(
    .DATA_W(32), .ADDR_W(32), .MEM_BYTES(65536),
    .BASE_ADDR(32'h8000_0000), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .s_axi_aclk(clk),
    .s_axi_resetn(rst_n),
    .s_axi(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Beat address from the burst definition, independent of the RTL formula.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                            input int size, input logic [1:0] burst, input int i);
    logic [31:0] s, total, base;
    s     = 32'd1 << size;
    total = 32'(len + 1) * s;
    case (burst)
      BURST_FIXED: return start;
      BURST_INCR:  return (i == 0) ? start : (start / s) * s + 32'(i) * s;
      default: begin
        base = (start / total) * total;
        return base + ((start - base + 32'(i) * s) % total);
      end
    endcase
  endfunction

  function automatic logic [31:0] model_get(input logic [31:0] a);
    logic [31:0] key;
    key = a & ~32'h3;
    return model.exists(key) ? model[key] : 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_write(input logic [31:0] addr, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst,
                                      input logic [31:0] d0, input logic [31:0] step,
                                      input logic [3:0] strb, input int wlast_beat,
                                      input logic [1:0] exp_resp, input bit commit);
    int n;
    logic [31:0] a, key, old, nw, d;
    b_q.push_back(exp_resp);
    bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < TMO) begin tick(); n++; end
    if (n >= TMO) check_output("aw_timeout", 32'(n), 32'h0);
    tick();
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      d = d0 + 32'(i) * step;
      bus.wdata = d; bus.wstrb = strb;
      bus.wlast = (wlast_beat >= 0) ? (i == wlast_beat) : (i == int'(len));
      bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < TMO) begin tick(); n++; end
      if (n >= TMO) check_output("w_timeout", 32'(n), 32'h0);
      tick();
      if (commit) begin
        a   = beat_addr(addr, int'(len), int'(size), burst, i);
        key = a & ~32'h3;
        old = model_get(a);
        for (int b = 0; b < 4; b++) nw[8*b +: 8] = strb[b] ? d[8*b +: 8] : old[8*b +: 8];
        model[key] = nw;
      end
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check_output("bvalid_after_last_w", 32'(bus.bvalid), 32'h1);
    bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < TMO) begin tick(); n++; end
    if (n >= TMO) check_output("b_timeout", 32'(n), 32'h0);
    check_output("bresp", 32'(bus.bresp), 32'(b_q.pop_front()));
    tick();
    bus.bready = 1'b0;
    check_output("awready_after_b", 32'(bus.awready), 32'h1);
  endtask

  task automatic apply_stimulus_read(input logic [31:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst,
                                     input logic [1:0] exp_resp, input bit toggle);
    int n, lat, beats;
    bit stalled;
    logic [31:0] held_data;
    logic held_last;
    rbeat_t e;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = (exp_resp == RESP_OKAY) ? model_get(beat_addr(addr, int'(len), int'(size), burst, i)) : 32'h0;
      e.resp = exp_resp;
      e.last = (i == int'(len));
      r_q.push_back(e);
    end
    bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < TMO) begin tick(); n++; end
    if (n >= TMO) check_output("ar_timeout", 32'(n), 32'h0);
    tick();
    bus.arvalid = 1'b0;
    lat = 1;
    while (!bus.rvalid && lat < TMO) begin tick(); lat++; end
    check_output("r_first_latency", 32'(lat), 32'(RD_LATENCY));
    beats = 0; n = 0; stalled = 1'b0; held_data = '0; held_last = 1'b0;
    while (beats <= int'(len) && n < TMO) begin
      bus.rready = toggle ? ((n % 2) == 1) : 1'b1;
      if (stalled) begin
        check_output("rvalid_stall_hold", 32'(bus.rvalid), 32'h1);
        check_output("rdata_stall_hold", bus.rdata, held_data);
        check_output("rlast_stall_hold", 32'(bus.rlast), 32'(held_last));
        stalled = 1'b0;
      end
      if (bus.rvalid && bus.rready) begin
        e = r_q.pop_front();
        check_output($sformatf("rdata_beat%0d", beats), bus.rdata, e.data);
        check_output($sformatf("rresp_beat%0d", beats), 32'(bus.rresp), 32'(e.resp));
        check_output($sformatf("rlast_beat%0d", beats), 32'(bus.rlast), 32'(e.last));
        beats++;
      end else if (bus.rvalid) begin
        stalled   = 1'b1;
        held_data = bus.rdata;
        held_last = bus.rlast;
      end
      tick();
      n++;
    end
    bus.rready = 1'b0;
    if (beats <= int'(len)) check_output("r_beats_timeout", 32'(beats), 32'(len) + 1);
    check_output("rvalid_after_last", 32'(bus.rvalid), 32'h0);
    check_output("arready_after_last", 32'(bus.arready), 32'h1);
  endtask

  initial begin
    bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    // Reset values
    repeat (3) tick();
    check_output("rst_awready", 32'(bus.awready), 32'h0);
    check_output("rst_wready",  32'(bus.wready),  32'h0);
    check_output("rst_bvalid",  32'(bus.bvalid),  32'h0);
    check_output("rst_bresp",   32'(bus.bresp),   32'h0);
    check_output("rst_arready", 32'(bus.arready), 32'h0);
    check_output("rst_rvalid",  32'(bus.rvalid),  32'h0);
    check_output("rst_rlast",   32'(bus.rlast),   32'h0);
    check_output("rst_rresp",   32'(bus.rresp),   32'h0);
    check_output("rst_rdata",   bus.rdata,        32'h0);
    rst_n = 1'b1;
    #1;
    check_output("awready_at_release", 32'(bus.awready), 32'h0);
    tick();
    check_output("awready_after_release", 32'(bus.awready), 32'h1);
    check_output("arready_after_release", 32'(bus.arready), 32'h1);
    $display("[TB] reset checks done");

    // INCR write and readback
    apply_stimulus_write(32'h8000_0000, 8'd3, 3'd2, BURST_INCR, 32'h11, 32'h11, 4'hF, -1, RESP_OKAY, 1'b1);
    apply_stimulus_read (32'h8000_0000, 8'd3, 3'd2, BURST_INCR, RESP_OKAY, 1'b0);

    // WRAP write starting mid-window; read back linearly and as WRAP
    apply_stimulus_write(32'h8000_0008, 8'd3, 3'd2, BURST_WRAP, 32'hA1, 32'h1, 4'hF, -1, RESP_OKAY, 1'b1);
    apply_stimulus_read (32'h8000_0000, 8'd3, 3'd2, BURST_INCR, RESP_OKAY, 1'b0);
    apply_stimulus_read (32'h8000_0008, 8'd3, 3'd2, BURST_WRAP, RESP_OKAY, 1'b0);

    // Partial strobe over a zeroed word
    apply_stimulus_write(32'h8000_0020, 8'd0, 3'd2, BURST_INCR, 32'h0, 32'h0, 4'hF, -1, RESP_OKAY, 1'b1);
    apply_stimulus_write(32'h8000_0020, 8'd0, 3'd2, BURST_INCR, 32'hAABB_CCDD, 32'h0, 4'b0010, -1, RESP_OKAY, 1'b1);
    apply_stimulus_read (32'h8000_0020, 8'd0, 3'd2, BURST_INCR, RESP_OKAY, 1'b0);
    check_output("strobe_model_word", model_get(32'h8000_0020), 32'h0000_CC00);

    // Decode errors; storage at the aliased word must be untouched
    apply_stimulus_read (32'h0000_0000, 8'd1, 3'd2, BURST_INCR, RESP_DECERR, 1'b0);
    apply_stimulus_write(32'h0000_0000, 8'd1, 3'd2, BURST_INCR, 32'hDEAD_BEEF, 32'h0, 4'hF, -1, RESP_DECERR, 1'b0);
    apply_stimulus_read (32'h8000_0000, 8'd1, 3'd2, BURST_INCR, RESP_OKAY, 1'b0);

    // LEN=7 read with RREADY toggling every cycle
    apply_stimulus_write(32'h8000_0040, 8'd7, 3'd2, BURST_INCR, 32'h1000_0001, 32'h0101_0101, 4'hF, -1, RESP_OKAY, 1'b1);
    apply_stimulus_read (32'h8000_0040, 8'd7, 3'd2, BURST_INCR, RESP_OKAY, 1'b1);

    // Early WLAST: burst completes by count, data kept, SLVERR
    apply_stimulus_write(32'h8000_0080, 8'd3, 3'd2, BURST_INCR, 32'h5000, 32'h1, 4'hF, 1, RESP_SLVERR, 1'b1);
    apply_stimulus_read (32'h8000_0080, 8'd3, 3'd2, BURST_INCR, RESP_OKAY, 1'b0);

    // Slave errors: illegal WRAP length and oversize beats
    apply_stimulus_read (32'h8000_0000, 8'd2, 3'd2, BURST_WRAP, RESP_SLVERR, 1'b0);
    apply_stimulus_read (32'h8000_0000, 8'd0, 3'd3, BURST_INCR, RESP_SLVERR, 1'b0);

    // FIXED burst: every beat lands on the same word
    apply_stimulus_write(32'h8000_0060, 8'd2, 3'd2, BURST_FIXED, 32'h1, 32'h1, 4'hF, -1, RESP_OKAY, 1'b1);
    apply_stimulus_read (32'h8000_0060, 8'd0, 3'd2, BURST_FIXED, RESP_OKAY, 1'b0);
    check_output("fixed_model_word", model_get(32'h8000_0060), 32'h3);

    // Reset in the middle of a read burst
    bus.araddr = 32'h8000_0040; bus.arlen = 8'd7; bus.arsize = 3'd2; bus.arburst = BURST_INCR;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    repeat (3) tick();
    check_output("midread_rvalid_before_reset", 32'(bus.rvalid), 32'h1);
    rst_n = 1'b0;
    #1;
    check_output("midread_rvalid_async", 32'(bus.rvalid), 32'h0);
    tick();
    check_output("midread_rvalid_next_edge", 32'(bus.rvalid), 32'h0);
    check_output("midread_arready_in_reset", 32'(bus.arready), 32'h0);
    bus.rready = 1'b0;
    rst_n = 1'b1;
    tick();
    apply_stimulus_read (32'h8000_0000, 8'd0, 3'd2, BURST_INCR, RESP_OKAY, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
